// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion definitions: round count, word/index types,
// sequencer states, forward S-box and round-constant lookup.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  rnd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  // Index 0 occupies the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input rnd_t r);
    logic [7:0] v;
    unique case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_schedule.sv
// One AES-128 key-expansion round: RotWord/SubWord/Rcon on the last word,
// then the xor chain across all words. Byte 0 of each word sits in [7:0].
module key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic [3:0]  rc,
  input  logic [31:0] key_current [NUM_WORDS],
  output logic [31:0] key_next    [NUM_WORDS]
);

  word_t rot;
  word_t sub;
  word_t acc;

  always_comb begin
    rot = {key_current[NUM_WORDS-1][7:0], key_current[NUM_WORDS-1][31:8]};
    sub = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      sub[8*b +: 8] = SBOX[rot[8*b +: 8]];
    end
    acc = sub ^ {24'h0, rcon(rc)};
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      acc         = acc ^ key_current[i];
      key_next[i] = acc;
    end
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key-expansion sequencer with an 11-entry round-key file.
// Optional KEY_EXPAND_ZEROIZE_EN adds a zeroize input that wipes all key state.
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [31:0] key_in     [NUM_WORDS],
  output logic        keys_valid,
  output logic        busy,
  input  logic [3:0]  rk_rd_idx,
  output logic [31:0] rk_rd_data [NUM_WORDS]
`ifdef KEY_EXPAND_ZEROIZE_EN
  ,
  input  logic        zeroize
`endif
);

  state_t state;
  rnd_t   rc;
  word_t  work     [NUM_WORDS];
  word_t  key_next [NUM_WORDS];
  word_t  rk       [NUM_ROUNDS+1][NUM_WORDS];
  logic   ready_q;
  logic   clear_req;

`ifdef KEY_EXPAND_ZEROIZE_EN
  assign clear_req = zeroize;
  assign key_ready = ready_q & ~zeroize;
`else
  assign clear_req = 1'b0;
  assign key_ready = ready_q;
`endif

  key_schedule #(.NUM_WORDS(NUM_WORDS)) u_key_schedule (
    .rc          (rc),
    .key_current (work),
    .key_next    (key_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rc         <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int unsigned j = 0; j < NUM_WORDS; j++) begin
        work[j] <= '0;
        for (int unsigned r = 0; r <= NUM_ROUNDS; r++) rk[r][j] <= '0;
      end
    end else if (clear_req) begin
      state      <= IDLE;
      rc         <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int unsigned j = 0; j < NUM_WORDS; j++) begin
        work[j] <= '0;
        for (int unsigned r = 0; r <= NUM_ROUNDS; r++) rk[r][j] <= '0;
      end
    end else begin
      unique case (state)
        EXPAND: begin
          rk[rc + rnd_t'(1)] <= key_next;
          work               <= key_next;
          if (rc == rnd_t'(NUM_ROUNDS - 1)) begin
            // rc parks at 0 so the schedule input never sees an out-of-range round
            rc         <= '0;
            state      <= DONE;
            ready_q    <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            rc <= rc + rnd_t'(1);
          end
        end
        default: begin
          if (key_valid) begin
            rk[0]      <= key_in;
            work       <= key_in;
            rc         <= '0;
            state      <= EXPAND;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_WORDS; j++) rk_rd_data[j] = '0;
    if (rk_rd_idx <= rnd_t'(NUM_ROUNDS)) rk_rd_data = rk[rk_rd_idx];
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Self-checking bench for key_expand_ctrl against a FIPS-197 byte-oriented
// key-expansion model with an S-box derived from GF(2^8) inversion.
module tb_key_expand_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [31:0] key_in [4];
  logic        keys_valid;
  logic        busy;
  logic [3:0]  rk_rd_idx = '0;
  logic [31:0] rk_rd_data [4];
`ifdef KEY_EXPAND_ZEROIZE_EN
  logic        zeroize = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  key_expand_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .keys_valid (keys_valid),
    .busy       (busy),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
`ifdef KEY_EXPAND_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Keys are held as FIPS-197 hex strings: word 0 in [127:96], byte 0 as MSB of each word.
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcv;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcv, 24'h0};
        rcv = xtime(rcv);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rd_fips();
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[127-32*j -: 32] = bswap(rk_rd_data[j]);
    return r;
  endfunction

  task automatic drive_key(input logic [127:0] k);
    for (int j = 0; j < 4; j++) key_in[j] = bswap(k[127-32*j -: 32]);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    n = 0;
    while (!key_ready && n < 20) begin tick(); n++; end
    if (!key_ready) begin
      vectors++; miscompares++;
      $display("FAIL load_wait key_ready got %b want 1", key_ready);
    end
    drive_key(k);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!keys_valid && n < 20) begin tick(); n++; end
    if (!keys_valid) begin
      vectors++; miscompares++;
      $display("FAIL wait_done keys_valid got %b want 1", keys_valid);
    end
  endtask

  task automatic test_reset();
    drive_key('0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({key_ready, keys_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 100", {key_ready, keys_valid, busy});
    end
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = i[3:0]; #1;
      vectors++;
      if (rd_fips() !== '0) begin
        miscompares++;
        $display("FAIL reset_rk idx=%0d got %h want 0", i, rd_fips());
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_vector();
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    load_key(k);
    vectors++;
    if ({busy, key_ready, keys_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL accept_flags busy/ready/valid got %b want 100", {busy, key_ready, keys_valid});
    end
    for (int c = 1; c < 10; c++) begin
      tick();
      vectors++;
      if (keys_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL latency cycle=%0d valid/busy got %b%b want 01", c, keys_valid, busy);
      end
    end
    tick();
    vectors++;
    if ({busy, key_ready, keys_valid} !== 3'b011) begin
      miscompares++;
      $display("FAIL done_flags busy/ready/valid got %b want 011", {busy, key_ready, keys_valid});
    end
    rk_rd_idx = 4'd0; #1;
    vectors++;
    if (rd_fips() !== k) begin
      miscompares++; $display("FAIL fips_rk0 got %h want %h", rd_fips(), k);
    end
    rk_rd_idx = 4'd1; #1;
    vectors++;
    if (rd_fips() !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      miscompares++; $display("FAIL fips_rk1 got %h want a0fafe1788542cb123a339392a6c7605", rd_fips());
    end
    rk_rd_idx = 4'd10; #1;
    vectors++;
    if (rd_fips() !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++; $display("FAIL fips_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_fips());
    end
  endtask

  task automatic test_read_sweep();
    logic [127:0] k;
    logic [127:0] e;
    k = rand_key();
    model_expand(k);
    load_key(k);
    wait_done();
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = i[3:0]; #1;
      e = '0;
      if (i <= 10) e = exp_rk[i];
      vectors++;
      if (rd_fips() !== e) begin
        miscompares++;
        $display("FAIL sweep idx=%0d got %h want %h", i, rd_fips(), e);
      end
    end
  endtask

  task automatic test_hold_during_expand();
    logic [127:0] ka;
    logic [127:0] kb;
    ka = rand_key();
    kb = ~ka;
    rk_rd_idx = 4'd0;
    drive_key(ka);
    key_valid = 1'b1;
    tick();
    drive_key(kb);
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (key_ready !== 1'b0 || rd_fips() !== ka) begin
        miscompares++;
        $display("FAIL hold cycle=%0d ready got %b want 0 rk0 got %h want %h", c, key_ready, rd_fips(), ka);
      end
      tick();
    end
    vectors++;
    if (keys_valid !== 1'b1 || rd_fips() !== ka) begin
      miscompares++;
      $display("FAIL hold_done valid got %b want 1 rk0 got %h want %h", keys_valid, rd_fips(), ka);
    end
    tick();
    key_valid = 1'b0;
    vectors++;
    if (keys_valid !== 1'b0 || busy !== 1'b1 || rd_fips() !== kb) begin
      miscompares++;
      $display("FAIL hold_accept valid/busy got %b%b want 01 rk0 got %h want %h", keys_valid, busy, rd_fips(), kb);
    end
    model_expand(kb);
    wait_done();
    for (int i = 0; i < 11; i++) begin
      rk_rd_idx = i[3:0]; #1;
      vectors++;
      if (rd_fips() !== exp_rk[i]) begin
        miscompares++;
        $display("FAIL hold_rk idx=%0d got %h want %h", i, rd_fips(), exp_rk[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_key(rand_key());
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({key_ready, keys_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_flags got %b want 100", {key_ready, keys_valid, busy});
    end
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = i[3:0]; #0;
      vectors++;
      if (rd_fips() !== '0) begin
        miscompares++;
        $display("FAIL midreset_rk idx=%0d got %h want 0", i, rd_fips());
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_key();
    model_expand('0);
    load_key('0);
    wait_done();
    rk_rd_idx = 4'd1; #1;
    vectors++;
    if (rd_fips() !== 128'h62636363626363636263636362636363) begin
      miscompares++; $display("FAIL zero_rk1 got %h want 62636363626363636263636362636363", rd_fips());
    end
    rk_rd_idx = 4'd10; #1;
    vectors++;
    if (rd_fips() !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      miscompares++; $display("FAIL zero_rk10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", rd_fips());
    end
    rk_rd_idx = 4'd5; #1;
    vectors++;
    if (rd_fips() !== exp_rk[5]) begin
      miscompares++; $display("FAIL zero_rk5 got %h want %h", rd_fips(), exp_rk[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      model_expand(k);
      load_key(k);
      vectors++;
      if (keys_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_restart run=%0d valid/busy got %b%b want 01", n, keys_valid, busy);
      end
      wait_done();
      for (int i = 0; i < 11; i++) begin
        rk_rd_idx = i[3:0]; #1;
        vectors++;
        if (rd_fips() !== exp_rk[i]) begin
          miscompares++;
          $display("FAIL b2b_rk run=%0d idx=%0d got %h want %h", n, i, rd_fips(), exp_rk[i]);
        end
      end
    end
  endtask

`ifdef KEY_EXPAND_ZEROIZE_EN
  task automatic test_zeroize();
    drive_key(rand_key());
    key_valid = 1'b1;
    zeroize   = 1'b1;
    #1;
    vectors++;
    if (key_ready !== 1'b0) begin
      miscompares++; $display("FAIL zeroize_ready got %b want 0", key_ready);
    end
    tick();
    key_valid = 1'b0;
    zeroize   = 1'b0;
    #1;
    vectors++;
    if ({key_ready, keys_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL zeroize_flags got %b want 100", {key_ready, keys_valid, busy});
    end
    for (int i = 0; i < 16; i++) begin
      rk_rd_idx = i[3:0]; #1;
      vectors++;
      if (rd_fips() !== '0) begin
        miscompares++;
        $display("FAIL zeroize_rk idx=%0d got %h want 0", i, rd_fips());
      end
    end
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_read_sweep();
    test_hold_during_expand();
    test_reset_mid();
    test_zero_key();
    test_back_to_back();
`ifdef KEY_EXPAND_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
